cosim_vec_sched: RTL and testbench

- Sequences directed stimulus vectors into a combinational or short-latency cosim DUT with a 128-bit `in` / 128-bit `out` interface.
- Per vector, it:
  - accepts the vector from a stimulus source over valid/ready;
  - drives the DUT input;
  - waits a fixed settle latency;
  - does a 4-state masked compare of the DUT output against the expected value.
- Sits between the cosim testbench vector ROM/driver and the DUT; reports pass/fail counts and the index of the first failing vector.

---
 rtl/cosim_vec_sched_pkg.sv | 17 +
 rtl/cosim_vec_cmp.sv | 21 ++
 rtl/cosim_vec_sched.sv | 128 ++++++++++++
 tb/tb_cosim_vec_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_vec_sched_pkg.sv
// Shared types and constants for the cosim vector scheduler.
package cosim_vec_sched_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Sliced down to NVEC_W by the users; all-ones marks "no failure seen".
    localparam logic [31:0] NO_FAIL = '1;

endpackage

// File: rtl/cosim_vec_cmp.sv
// Combinational 4-state masked compare: flags any cared-for bit of act that is
// not case-identical to exp (x/z included).
module cosim_vec_cmp #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] care,
    input  logic [WIDTH-1:0] act,
    output logic             mismatch
);

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((care[i] === 1'b1) && (act[i] !== exp[i])) begin
                mismatch = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cosim_vec_sched.sv
// Cosim vector scheduler: fetch, drive, settle, masked-compare, count.
// Optional: COSIM_VEC_SCHED_STOP_ON_FAIL_EN ends the run at the first mismatch.
module cosim_vec_sched
    import cosim_vec_sched_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int LAT    = 1,
    parameter int NVEC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NVEC_W-1:0] nvec,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [WIDTH-1:0]  vec_in,
    input  logic [WIDTH-1:0]  vec_exp,
    input  logic [WIDTH-1:0]  vec_care,
    output logic [WIDTH-1:0]  dut_in,
    input  logic [WIDTH-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic [NVEC_W-1:0] pass_cnt,
    output logic [NVEC_W-1:0] fail_cnt,
    output logic [NVEC_W-1:0] first_fail
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_FETCH  = FETCH;
    localparam logic [2:0] S_SETTLE = SETTLE;
    localparam logic [2:0] S_CHECK  = CHECK;
    localparam logic [2:0] S_DONE   = DONE;

    localparam logic [LAT_W-1:0]  LAT_V   = LAT_W'(LAT);
    localparam logic [NVEC_W-1:0] ONE     = NVEC_W'(1);
    localparam logic [NVEC_W-1:0] NOFAIL  = NO_FAIL[NVEC_W-1:0];

    logic [2:0]        state;
    logic [NVEC_W-1:0] idx;
    logic [NVEC_W-1:0] idx_nx;
    logic [NVEC_W-1:0] nvec_r;
    logic [LAT_W-1:0]  set_cnt;
    logic [WIDTH-1:0]  exp_r;
    logic [WIDTH-1:0]  care_r;
    logic              mismatch;

    function automatic logic [NVEC_W-1:0] sat_inc(input logic [NVEC_W-1:0] v);
        return (v == NOFAIL) ? v : v + ONE;
    endfunction

    cosim_vec_cmp #(.WIDTH(WIDTH)) u_cmp (
        .exp      (exp_r),
        .care     (care_r),
        .act      (dut_out),
        .mismatch (mismatch)
    );

    assign idx_nx    = idx + ONE;
    assign vec_ready = (state == S_FETCH);
    assign busy      = (state == S_FETCH) || (state == S_SETTLE) || (state == S_CHECK);
    assign done      = (state == S_DONE);

    // Expected/care are pure data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (state == S_FETCH && vec_valid) begin
            exp_r  <= vec_exp;
            care_r <= vec_care;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dut_in     <= '0;
            idx        <= '0;
            nvec_r     <= '0;
            set_cnt    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= NOFAIL;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        first_fail <= NOFAIL;
                        idx        <= '0;
                        nvec_r     <= nvec;
                        state      <= (nvec == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (vec_valid) begin
                        dut_in  <= vec_in;
                        set_cnt <= LAT_V;
                        state   <= (LAT_V == '0) ? S_CHECK : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (set_cnt <= LAT_W'(1)) begin
                        state <= S_CHECK;
                    end else begin
                        set_cnt <= set_cnt - LAT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        fail_cnt <= sat_inc(fail_cnt);
                        if (first_fail == NOFAIL) begin
                            first_fail <= idx;
                        end
                    end else begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end
                    idx <= idx_nx;
`ifdef COSIM_VEC_SCHED_STOP_ON_FAIL_EN
                    state <= (idx_nx == nvec_r || mismatch) ? S_DONE : S_FETCH;
`else
                    state <= (idx_nx == nvec_r) ? S_DONE : S_FETCH;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cosim_vec_sched.sv
// Scoreboard bench for cosim_vec_sched: stimulus pushes expected dut_in values
// and run results; monitors pop and compare on accepts and on done rising.
module tb_cosim_vec_sched;

    localparam int W  = 128;
    localparam int NW = 8;
    localparam logic [W-1:0] XIN  = 128'hA;
    localparam logic [W-1:0] ZIN  = 128'hB;
    localparam logic [W-1:0] ALL1 = '1;

    typedef struct packed {
        logic [NW-1:0] p;
        logic [NW-1:0] f;
        logic [NW-1:0] ff;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] nvec = '0;
    logic          vec_valid = 1'b0;
    logic          vec_ready;
    logic [W-1:0]  vec_in = '0;
    logic [W-1:0]  vec_exp = '0;
    logic [W-1:0]  vec_care = '0;
    logic [W-1:0]  dut_in;
    logic [W-1:0]  dut_out;
    logic          busy;
    logic          done;
    logic [NW-1:0] pass_cnt;
    logic [NW-1:0] fail_cnt;
    logic [NW-1:0] first_fail;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    logic acc_m = 1'b0;
    logic done_q = 1'b0;
    res_t r_m;

    logic [W-1:0] q_din[$];
    res_t         q_res[$];

    cosim_vec_sched #(.WIDTH(W), .LAT(1), .NVEC_W(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .nvec       (nvec),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_in     (vec_in),
        .vec_exp    (vec_exp),
        .vec_care   (vec_care),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .first_fail (first_fail)
    );

    // Device under cosim: a buffer, except two tagged inputs that answer with x or z.
    function automatic logic [W-1:0] dut_model(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
        if (d == XIN) begin
            r = '0;
            r[7] = 1'bx;
        end else if (d == ZIN) begin
            r = '0;
            r[0] = 1'bz;
        end
        return r;
    endfunction

    assign dut_out = dut_model(dut_in);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic [NW-1:0] p, input logic [NW-1:0] f,
                              input logic [NW-1:0] ff);
        res_t r;
        r.p  = p;
        r.f  = f;
        r.ff = ff;
        q_res.push_back(r);
    endtask

    task automatic send_vec(input logic [W-1:0] vi, input logic [W-1:0] ve,
                            input logic [W-1:0] vc);
        int n;
        n = 0;
        q_din.push_back(vi);
        vec_in    = vi;
        vec_exp   = ve;
        vec_care  = vc;
        vec_valid = 1'b1;
        while (!vec_ready && n < 50) begin
            step();
            n++;
        end
        if (!vec_ready) chk("accept_timeout", W'(vec_ready), W'(1'b1));
        step();
        vec_valid = 1'b0;
    endtask

    task automatic start_run(input logic [NW-1:0] n, output int c0);
        nvec  = n;
        start = 1'b1;
        step();
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic wait_done(output int c1);
        int n;
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        chk("done_reached", W'(done), W'(1'b1));
        c1 = cyc;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dut_in"},     dut_in,          '0);
        chk({tag, "_busy"},       W'(busy),        W'(1'b0));
        chk({tag, "_done"},       W'(done),        W'(1'b0));
        chk({tag, "_vec_ready"},  W'(vec_ready),   W'(1'b0));
        chk({tag, "_pass_cnt"},   W'(pass_cnt),    W'(0));
        chk({tag, "_fail_cnt"},   W'(fail_cnt),    W'(0));
        chk({tag, "_first_fail"}, W'(first_fail),  W'(8'hFF));
    endtask

    // Accept monitor: every handshake must put the next queued stimulus on dut_in.
    initial forever begin
        @(posedge clk);
        acc_m = vec_valid && vec_ready && rst_n;
        @(negedge clk);
        if (acc_m) begin
            if (q_din.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL dut_in_unexpected: actual=%0h required=none", dut_in);
            end else begin
                chk("dut_in", dut_in, q_din.pop_front());
            end
        end
    end

    // Result monitor: each run completion is checked against the queued expectation.
    initial forever begin
        @(negedge clk);
        if (done && !done_q) begin
            if (q_res.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL done_unexpected: actual=%0d/%0d required=none", pass_cnt, fail_cnt);
            end else begin
                r_m = q_res.pop_front();
                chk("res_pass_cnt",   W'(pass_cnt),   W'(r_m.p));
                chk("res_fail_cnt",   W'(fail_cnt),   W'(r_m.f));
                chk("res_first_fail", W'(first_fail), W'(r_m.ff));
            end
        end
        done_q = done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst_n = 1'b1;
        step();

        // Basic pass, continuous valid: 3 vectors x 3 cycles.
        expect_res(8'd3, 8'd0, 8'hFF);
        start_run(8'd3, c0);
        send_vec(W'(1), W'(1), ALL1);
        send_vec(W'(2), W'(2), ALL1);
        send_vec(W'(3), W'(3), ALL1);
        wait_done(c1);
        chk("t1_latency", W'(c1 - c0), W'(9));
        chk("t1_busy_done", W'(busy), W'(1'b0));

        // Masked x passes, z against a known 1 fails at index 2.
        expect_res(8'd2, 8'd1, 8'd2);
        start_run(8'd3, c0);
        send_vec(W'(5), W'(5), ALL1);
        send_vec(XIN, '0, W'(8'h0F));
        send_vec(ZIN, W'(1), W'(1));
        wait_done(c1);

        // Backpressure in FETCH.
        expect_res(8'd2, 8'd0, 8'hFF);
        start_run(8'd2, c0);
        send_vec(W'(16'h1234), W'(16'h1234), ALL1);
        begin
            int n;
            n = 0;
            while (!vec_ready && n < 20) begin
                step();
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_vec_ready", W'(vec_ready), W'(1'b1));
            chk("bp_dut_in",    dut_in,        W'(16'h1234));
            chk("bp_pass_cnt",  W'(pass_cnt),  W'(1));
            step();
        end
        send_vec(W'(16'h5678), W'(16'h5678), ALL1);
        wait_done(c1);

        // Reset while a vector is settling.
        start_run(8'd3, c0);
        send_vec(W'(16'hC0DE), W'(16'hC0DE), ALL1);
        chk("mid_busy", W'(busy), W'(1'b1));
        rst_n = 1'b0;
        step();
        chk_reset_state("midrst");
        rst_n = 1'b1;

        // Empty run, then a start pulse while busy that must be ignored.
        expect_res(8'd0, 8'd0, 8'hFF);
        start_run(8'd0, c0);
        chk("nv0_done", W'(done), W'(1'b1));
        chk("nv0_busy", W'(busy), W'(1'b0));
        step();
        expect_res(8'd2, 8'd0, 8'hFF);
        start_run(8'd2, c0);
        nvec  = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_busy",      W'(busy),      W'(1'b1));
        chk("ign_vec_ready", W'(vec_ready), W'(1'b1));
        send_vec(W'(16'h1111), W'(16'h1111), ALL1);
        send_vec(W'(16'h2222), W'(16'h2222), ALL1);
        wait_done(c1);

        // Vector 1 fails out of four.
`ifdef COSIM_VEC_SCHED_STOP_ON_FAIL_EN
        expect_res(8'd1, 8'd1, 8'd1);
        start_run(8'd4, c0);
        send_vec(W'(3), W'(3), ALL1);
        send_vec(W'(7), W'(8), ALL1);
        wait_done(c1);
`else
        expect_res(8'd3, 8'd1, 8'd1);
        start_run(8'd4, c0);
        send_vec(W'(3), W'(3), ALL1);
        send_vec(W'(7), W'(8), ALL1);
        send_vec(W'(9), W'(9), ALL1);
        send_vec(W'(4), W'(4), ALL1);
        wait_done(c1);
`endif

        repeat (3) step();
        chk("q_din_drained", W'(q_din.size()), W'(0));
        chk("q_res_drained", W'(q_res.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
